// File: rtl/seg7_disp32_if.sv
// Bus between the display-source selector and the seven-segment display stage.
// The selector drives the word and mode bits; the display stage drives segments and status.
interface seg7_disp32_if;
  logic [31:0] data;
  logic        hex_mode;
  logic        is_signed;
  logic        force_conv;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;
  logic [6:0]  hex4;
  logic [6:0]  hex5;
  logic [6:0]  hex6;
  logic [6:0]  hex7;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (
    output data, hex_mode, is_signed, force_conv,
    input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, done, ovf
  );

  modport slave (
    input  data, hex_mode, is_signed, force_conv,
    output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, busy, done, ovf
  );
endinterface

// File: rtl/seg7_disp32.sv
// Eight-digit seven-segment display stage: raw hex, or decimal through a
// sequential double-dabble with sign, leading-zero blanking and overflow.
module seg7_disp32 #(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_disp32_if.slave  bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BCD_DIG = 10;
  localparam int unsigned BCD_W   = 4 * BCD_DIG;
  localparam int unsigned DIGITS  = 8;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned CNT_W   = 5;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_ERR   = 7'h06;

  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

  state_t              state_q;
  logic                valid_q;
  logic [DATA_W-1:0]   snap_data_q;
  logic                snap_sgn_q;
  logic                snap_hex_q;
  logic                neg_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [DATA_W-1:0]   opnd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [SEG_W-1:0]    hex_q [DIGITS];

  logic [BCD_W-1:0]    bcd_adj_c;
  logic [SEG_W-1:0]    seg_c [DIGITS];
  logic                ovf_c;
  logic [2:0]          msd_c;
  logic                start_c;
  logic                neg_in_c;

  function automatic logic [SEG_W-1:0] seg_of(input logic [3:0] n);
    logic [SEG_W-1:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // New conversion when forced, never converted, or any input differs from the snapshot.
  always_comb begin
    start_c  = bus.force_conv || !valid_q ||
               ({bus.is_signed, bus.hex_mode, bus.data} != {snap_sgn_q, snap_hex_q, snap_data_q});
    neg_in_c = bus.is_signed && bus.data[DATA_W-1] && !bus.hex_mode;
  end

  // Double-dabble correction: add 3 to every BCD digit of 5 or more before shifting.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(BCD_DIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Final digit formatting from the snapshot and the finished BCD value.
  always_comb begin
    ovf_c = 1'b0;
    msd_c = 3'd0;
    for (int i = 0; i < int'(DIGITS); i++) seg_c[i] = SEG_BLANK;
    if (snap_hex_q) begin
      for (int i = 0; i < int'(DIGITS); i++) seg_c[i] = seg_of(snap_data_q[4*i +: 4]);
    end else begin
      ovf_c = neg_q ? (|bcd_q[BCD_W-1:28]) : (|bcd_q[BCD_W-1:32]);
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (bcd_q[4*i +: 4] != 4'd0) msd_c = 3'(i);
      end
      if (ovf_c) begin
        seg_c[0] = SEG_ERR;
      end else begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (!LZ_BLANK || (3'(i) <= msd_c)) seg_c[i] = seg_of(bcd_q[4*i +: 4]);
        end
        // A non-overflowing negative value has at most seven digits, so msd_c + 1 stays in range.
        if (neg_q) begin
          if (LZ_BLANK) seg_c[3'(msd_c + 3'd1)] = SEG_MINUS;
          else          seg_c[DIGITS-1]         = SEG_MINUS;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      snap_data_q <= '0;
      snap_sgn_q  <= 1'b0;
      snap_hex_q  <= 1'b0;
      neg_q       <= 1'b0;
      bcd_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) hex_q[i] <= SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_c) begin
            valid_q     <= 1'b1;
            snap_data_q <= bus.data;
            snap_sgn_q  <= bus.is_signed;
            snap_hex_q  <= bus.hex_mode;
            neg_q       <= neg_in_c;
            bcd_q       <= '0;
            opnd_q      <= neg_in_c ? DATA_W'(~bus.data + 32'd1) : bus.data;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= bus.hex_mode ? FORMAT : SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, opnd_q} <= {bcd_adj_c[BCD_W-2:0], opnd_q, 1'b0};
          cnt_q           <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FORMAT;
        end
        FORMAT: begin
          for (int i = 0; i < int'(DIGITS); i++) hex_q[i] <= seg_c[i];
          ovf_q   <= ovf_c;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hex0 = hex_q[0];
  assign bus.hex1 = hex_q[1];
  assign bus.hex2 = hex_q[2];
  assign bus.hex3 = hex_q[3];
  assign bus.hex4 = hex_q[4];
  assign bus.hex5 = hex_q[5];
  assign bus.hex6 = hex_q[6];
  assign bus.hex7 = hex_q[7];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule
